// File: rtl/mux_scan_sequencer_pkg.sv
// rtl/mux_scan_sequencer_pkg.sv - shared types and constants for the mux scan sequencer
// Contents: scan FSM state enum, default SEL_W/DWELL values, dwell counter width.
package mux_scan_sequencer_pkg;

  localparam int SEL_W_DEFAULT = 2;
  localparam int DWELL_DEFAULT = 4;
  localparam int CNT_W         = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mux_scan_sequencer_if.sv
// rtl/mux_scan_sequencer_if.sv - control/sample bundle between a host and the scan sequencer
// Signals: start, abort, y_in (host -> sequencer); sel, busy, done, data_out (sequencer -> host).
// Modports: master = host side, slave = sequencer side.
interface mux_scan_sequencer_if #(
  parameter int SEL_W = 2
);
  localparam int N = 2 ** SEL_W;

  logic             start;
  logic             abort;
  logic             y_in;
  logic [SEL_W-1:0] sel;
  logic             busy;
  logic             done;
  logic [N-1:0]     data_out;

  modport master (
    output start, abort, y_in,
    input  sel, busy, done, data_out
  );

  modport slave (
    input  start, abort, y_in,
    output sel, busy, done, data_out
  );
endinterface

// File: rtl/mux_scan_sequencer_dwell_timer.sv
// rtl/mux_scan_sequencer_dwell_timer.sv - loadable down-counter timing each select dwell
// Ports: clk, rst_n (sync, active-low); load_i/load_val_i load the count;
//        en_i allows a decrement; zero_o flags count == 0.
module dwell_timer
  import mux_scan_sequencer_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             en_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Decrement saturates at zero so the counter can never wrap.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mux_scan_sequencer.sv
// rtl/mux_scan_sequencer.sv - steps a 4:1 mux select through all inputs and captures its output
// Ports: clk, rst_n (sync, active-low); bus (slave): start/abort control, y_in sample input,
//        sel mux select, busy, done one-cycle completion pulse, data_out last completed scan.
module mux_scan_sequencer
  import mux_scan_sequencer_pkg::*;
#(
  parameter int SEL_W = SEL_W_DEFAULT,
  parameter int DWELL = DWELL_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mux_scan_sequencer_if.slave  bus
);

  localparam int               N        = 2 ** SEL_W;
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(N - 1);
  localparam logic [CNT_W-1:0] RELOAD   = CNT_W'(DWELL - 1);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [N-1:0]     shadow_q, shadow_d;
  logic [N-1:0]     data_out_q, data_out_d;
  logic             tmr_load, tmr_en, tmr_zero;

  dwell_timer u_dwell_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmr_load),
    .load_val_i (RELOAD),
    .en_i       (tmr_en),
    .zero_o     (tmr_zero)
  );

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      sel_q      <= '0;
      shadow_q   <= '0;
      data_out_q <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      shadow_q   <= shadow_d;
      data_out_q <= data_out_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    shadow_d   = shadow_q;
    data_out_d = data_out_q;
    tmr_load   = 1'b0;
    tmr_en     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        sel_d = '0;
        // abort is a no-op here, so start always wins
        if (bus.start) begin
          state_d  = ST_SCAN;
          tmr_load = 1'b1;
        end
      end
      ST_SCAN: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
          sel_d   = '0;
        end else if (!tmr_zero) begin
          tmr_en = 1'b1;
        end else begin
          shadow_d[sel_q] = bus.y_in;
          if (sel_q == SEL_LAST) begin
            // Publish the whole word at once, including the sample just taken.
            state_d    = ST_DONE;
            data_out_d = shadow_d;
          end else begin
            sel_d    = sel_q + SEL_W'(1);
            tmr_load = 1'b1;
          end
        end
      end
      ST_DONE: begin
        // start is ignored here, guaranteeing an IDLE cycle between scans
        state_d = ST_IDLE;
        sel_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        sel_d   = '0;
      end
    endcase
  end

  // Outputs decode from registers only
  always_comb begin
    bus.busy     = (state_q != ST_IDLE);
    bus.done     = (state_q == ST_DONE);
    bus.sel      = sel_q;
    bus.data_out = data_out_q;
  end

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// tb/tb_mux_scan_sequencer.sv - self-checking bench for mux_scan_sequencer
module tb_mux_scan_sequencer;

  localparam int SEL_W = 2;
  localparam int N     = 4;
  localparam int DW    = 4;
  localparam int SCAN  = N * DW;

  logic clk;
  logic rst_n;
  logic [3:0] mux_d;
  logic [3:0] mux_d1;

  int tests  = 0;
  int failed = 0;

  mux_scan_sequencer_if #(.SEL_W(SEL_W)) bus  ();
  mux_scan_sequencer_if #(.SEL_W(SEL_W)) bus1 ();

  mux_scan_sequencer #(.SEL_W(SEL_W), .DWELL(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  mux_scan_sequencer #(.SEL_W(SEL_W), .DWELL(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  // Behavioural 4:1 mux in front of each sequencer
  assign bus.y_in  = mux_d[bus.sel];
  assign bus1.y_in = mux_d1[bus1.sel];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         t;
    logic [1:0] sel;
    logic       busy;
    logic       done;
    logic       new_data;
  } vec_t;

  vec_t tab[10];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Runs one uninterrupted scan and compares against the per-cycle table.
  task automatic run_table(input logic [3:0] d, input logic [3:0] old);
    int t;
    mux_d     = d;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    t = 0;
    for (int i = 0; i < 10; i++) begin
      while (t < tab[i].t) begin
        step();
        t++;
      end
      chk($sformatf("tab sel t=%0d", t),  32'(bus.sel),  32'(tab[i].sel));
      chk($sformatf("tab busy t=%0d", t), 32'(bus.busy), 32'(tab[i].busy));
      chk($sformatf("tab done t=%0d", t), 32'(bus.done), 32'(tab[i].done));
      chk($sformatf("tab data t=%0d", t), 32'(bus.data_out),
          32'(tab[i].new_data ? d : old));
    end
  endtask

  initial begin
    logic [3:0] old;
    logic [3:0] d;
    int         abort_at;
    int         done_cnt;
    int         end_t;
    logic       aborted;
    logic [1:0] exp_sel;

    tab[0] = '{0,  2'd0, 1'b1, 1'b0, 1'b0};
    tab[1] = '{3,  2'd0, 1'b1, 1'b0, 1'b0};
    tab[2] = '{4,  2'd1, 1'b1, 1'b0, 1'b0};
    tab[3] = '{7,  2'd1, 1'b1, 1'b0, 1'b0};
    tab[4] = '{8,  2'd2, 1'b1, 1'b0, 1'b0};
    tab[5] = '{12, 2'd3, 1'b1, 1'b0, 1'b0};
    tab[6] = '{15, 2'd3, 1'b1, 1'b0, 1'b0};
    tab[7] = '{16, 2'd3, 1'b1, 1'b1, 1'b1};
    tab[8] = '{17, 2'd0, 1'b0, 1'b0, 1'b1};
    tab[9] = '{18, 2'd0, 1'b0, 1'b0, 1'b1};

    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.abort  = 1'b0;
    bus1.start = 1'b0;
    bus1.abort = 1'b0;
    mux_d      = 4'b0000;
    mux_d1     = 4'b0000;
    step();
    step();
    chk("reset busy", 32'(bus.busy), 32'd0);
    chk("reset sel",  32'(bus.sel), 32'd0);
    chk("reset done", 32'(bus.done), 32'd0);
    chk("reset data", 32'(bus.data_out), 32'd0);
    rst_n = 1'b1;
    step();

    // Nominal scan then data-hold scan
    run_table(4'b1010, 4'b0000);
    step();
    run_table(4'b0110, 4'b1010);

    // Reset in the middle of a scan
    mux_d     = 4'b1111;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 5; i++) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("midrst busy", 32'(bus.busy), 32'd0);
    chk("midrst sel",  32'(bus.sel), 32'd0);
    chk("midrst data", 32'(bus.data_out), 32'd0);
    chk("midrst done", 32'(bus.done), 32'd0);
    done_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.done) done_cnt++;
    end
    chk("midrst no done", 32'(done_cnt), 32'd0);

    // Abort mid-scan, then a normal scan
    mux_d     = 4'b0101;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 8; i++) step();
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    chk("abort busy", 32'(bus.busy), 32'd0);
    chk("abort sel",  32'(bus.sel), 32'd0);
    chk("abort data", 32'(bus.data_out), 32'd0);
    done_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.done) done_cnt++;
    end
    chk("abort no done", 32'(done_cnt), 32'd0);
    run_table(4'b0101, 4'b0000);

    // start while busy and in DONE is ignored
    mux_d     = 4'b0011;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    done_cnt  = 0;
    for (int t = 1; t <= 26; t++) begin
      bus.start = (t == 5 || t == 16 || t == 17);
      step();
      if (bus.done) begin
        done_cnt++;
        chk("reject done time", 32'(t), 32'(SCAN));
      end
    end
    bus.start = 1'b0;
    chk("reject done count", 32'(done_cnt), 32'd1);
    chk("reject idle",       32'(bus.busy), 32'd0);
    chk("reject data",       32'(bus.data_out), 32'(4'b0011));

    // Randomized scans with optional abort against an arithmetic model
    old = 4'b0011;
    for (int it = 0; it < 20; it++) begin
      d        = 4'($urandom);
      abort_at = $urandom_range(0, 24);
      aborted  = (abort_at >= 1 && abort_at <= SCAN);
      end_t    = aborted ? abort_at : SCAN + 1;
      mux_d    = d;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      for (int t = 1; t <= 22; t++) begin
        bus.abort = (t == abort_at);
        step();
        if (t >= end_t)      exp_sel = 2'd0;
        else if (t >= SCAN)  exp_sel = 2'(N - 1);
        else                 exp_sel = 2'(t / DW);
        chk($sformatf("rnd%0d sel t=%0d", it, t),  32'(bus.sel), 32'(exp_sel));
        chk($sformatf("rnd%0d busy t=%0d", it, t), 32'(bus.busy), 32'(t < end_t));
        chk($sformatf("rnd%0d done t=%0d", it, t), 32'(bus.done),
            32'(!aborted && t == SCAN));
        chk($sformatf("rnd%0d data t=%0d", it, t), 32'(bus.data_out),
            32'((!aborted && t >= SCAN) ? d : old));
      end
      bus.abort = 1'b0;
      if (!aborted) old = d;
    end

    // Single-cycle dwell instance
    for (int r = 0; r < 2; r++) begin
      d          = (r == 0) ? 4'b1111 : 4'b0100;
      old        = (r == 0) ? 4'b0000 : 4'b1111;
      mux_d1     = d;
      bus1.start = 1'b1;
      step();
      bus1.start = 1'b0;
      for (int t = 1; t <= 5; t++) begin
        step();
        chk($sformatf("dw1 sel t=%0d", t),  32'(bus1.sel),
            32'((t < N) ? t : ((t == N) ? N - 1 : 0)));
        chk($sformatf("dw1 done t=%0d", t), 32'(bus1.done), 32'(t == N));
        chk($sformatf("dw1 data t=%0d", t), 32'(bus1.data_out),
            32'((t >= N) ? d : old));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
